// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master core among NUM_REQ requesters.
// Latches each accepted command, sequences the core's start/end handshake and applies a watchdog.
module i2c_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_read,
    input  logic [7*NUM_REQ-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]      req_wlen,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [7:0]              rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    i2c_start,
    output logic                    i2c_read,
    output logic [6:0]              i2c_addr,
    output logic                    i2c_wlen,
    output logic [7:0]              i2c_wdata1,
    output logic [7:0]              i2c_wdata2,
    input  logic [7:0]              i2c_rdata,
    input  logic                    i2c_end,
    input  logic                    i2c_ack_err
);

    localparam int unsigned PtrW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StBusy,
        StDone,
        StAbort
    } state_e;

    state_e             state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [15:0]        wdog_q, wdog_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               read_q, read_d;
    logic [6:0]         addr_q, addr_d;
    logic               wlen_q, wlen_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               to_q, to_d;

    logic               grant_found;
    logic [PtrW-1:0]    grant_idx;
    logic [PtrW-1:0]    cand;
    logic               sel_read;
    logic [6:0]         sel_addr;
    logic               sel_wlen;
    logic [15:0]        sel_wdata;

    // Search starts just after the last grant so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        cand        = ptr_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = PtrW'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_read  = 1'b0;
        sel_addr  = '0;
        sel_wlen  = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PtrW'(i)) begin
                sel_read  = req_read[i];
                sel_addr  = req_addr[7*i +: 7];
                sel_wlen  = req_wlen[i];
                sel_wdata = req_wdata[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        ready_d = '0;
        read_d  = read_q;
        addr_d  = addr_q;
        wlen_d  = wlen_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        unique case (state_q)
            StIdle: begin
                if (i2c_end && grant_found) begin
                    state_d = StLaunch;
                    ptr_d   = grant_idx;
                    ready_d = OneHot0 << grant_idx;
                    wdog_d  = '0;
                    read_d  = sel_read;
                    addr_d  = sel_addr;
                    wlen_d  = sel_wlen;
                    wdata_d = sel_wdata;
                end
            end
            StLaunch, StBusy: begin
                if (wdog_q != 16'hFFFF) begin
                    wdog_d = wdog_q + 16'd1;
                end
                if (wdog_q >= TimeoutLast) begin
                    state_d = StAbort;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end else if (state_q == StLaunch && !i2c_end) begin
                    state_d = StBusy;
                end else if (state_q == StBusy && i2c_end) begin
                    // Capture on the way into StDone so the result is valid with rsp_valid.
                    state_d = StDone;
                    rdata_d = i2c_rdata;
                    err_d   = i2c_ack_err;
                    to_d    = 1'b0;
                end
            end
            StDone, StAbort: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= PtrW'(NUM_REQ - 1);
            wdog_q  <= '0;
            ready_q <= '0;
            read_q  <= 1'b0;
            addr_q  <= '0;
            wlen_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            ready_q <= ready_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            wlen_q  <= wlen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = (state_q == StDone || state_q == StAbort) ? (OneHot0 << ptr_q) : '0;
    assign rsp_rdata   = rdata_q;
    assign rsp_error   = err_q;
    assign rsp_timeout = to_q;
    assign i2c_start   = (state_q == StLaunch);
    assign i2c_read    = read_q;
    assign i2c_addr    = addr_q;
    assign i2c_wlen    = wlen_q;
    assign i2c_wdata1  = wdata_q[15:8];
    assign i2c_wdata2  = wdata_q[7:0];

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized bench for i2c_bus_arbiter: transaction-level reference model plus a simple core model.
module tb_i2c_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_read = '0;
    logic [7*N-1:0]  req_addr = '0;
    logic [N-1:0]  req_wlen = '0;
    logic [16*N-1:0] req_wdata = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [7:0]    rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          i2c_start;
    logic          i2c_read;
    logic [6:0]    i2c_addr;
    logic          i2c_wlen;
    logic [7:0]    i2c_wdata1;
    logic [7:0]    i2c_wdata2;
    logic [7:0]    i2c_rdata = '0;
    logic          i2c_end = 1'b1;
    logic          i2c_ack_err = 1'b0;

    i2c_bus_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_read    (req_read),
        .req_addr    (req_addr),
        .req_wlen    (req_wlen),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .i2c_start   (i2c_start),
        .i2c_read    (i2c_read),
        .i2c_addr    (i2c_addr),
        .i2c_wlen    (i2c_wlen),
        .i2c_wdata1  (i2c_wdata1),
        .i2c_wdata2  (i2c_wdata2),
        .i2c_rdata   (i2c_rdata),
        .i2c_end     (i2c_end),
        .i2c_ack_err (i2c_ack_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Requester command store
    logic        c_read  [N];
    logic [6:0]  c_addr  [N];
    logic        c_wlen  [N];
    logic [15:0] c_wdata [N];

    // Reference model state
    int          m_ptr = N - 1;
    bit          busy_m = 1'b0;
    int          owner = 0;
    int          t_grant = 0;
    int          cyc = 0;
    int          grants = 0;
    int          resps = 0;
    int          dropped = 0;
    int          gseq[$];
    logic [7:0]  last_rdata = '0;
    logic [N-1:0] valid_prev = '0;
    logic        end_prev = 1'b1;
    bit          saw_start = 1'b0;
    int          r_owner = -1;
    logic        r_err = 1'b0;
    logic        r_to = 1'b0;

    // Core model: mode 0 normal, 1 ignores start (end stays 1), 2 goes busy and never ends
    int          core_mode = 0;
    int          core_ph = 0;
    int          core_cnt = 0;
    int          ack_mode = 0;
    int          force_rd = -1;
    logic [7:0]  core_rdata = '0;
    logic        core_ack = 1'b0;

    // Requester mode: 0 none, 1 always requesting, 2 random raise/withdraw
    int          req_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_cmd(input int i, input logic rd, input logic [6:0] a, input logic wl,
                           input logic [15:0] wd);
        c_read[i]  = rd;
        c_addr[i]  = a;
        c_wlen[i]  = wl;
        c_wdata[i] = wd;
        req_read[i]          = rd;
        req_addr[7*i +: 7]   = a;
        req_wlen[i]          = wl;
        req_wdata[16*i +: 16] = wd;
        req_valid[i]         = 1'b1;
        valid_prev           = req_valid;
    endtask

    task automatic monitor();
        int gi;
        int ri;
        int pick;
        logic [7:0] e_rd;
        logic e_err;
        logic e_to;
        if (i2c_start) saw_start = 1'b1;
        if (rsp_valid != '0) begin
            ri = onehot_idx(rsp_valid);
            check("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
            check("rsp_outstanding", 32'(busy_m), 32'd1);
            check("rsp_owner", 32'(ri), 32'(owner));
            if (core_mode != 0) begin
                e_rd  = last_rdata;
                e_err = 1'b1;
                e_to  = 1'b1;
                check("timeout_latency", 32'(cyc - t_grant), 32'(TO));
            end else begin
                e_rd  = core_rdata;
                e_err = core_ack;
                e_to  = 1'b0;
            end
            check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
            check("rsp_error", 32'(rsp_error), 32'(e_err));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
            last_rdata = e_rd;
            r_owner = ri;
            r_err   = rsp_error;
            r_to    = rsp_timeout;
            busy_m  = 1'b0;
            resps++;
        end
        if (req_ready != '0) begin
            gi   = onehot_idx(req_ready);
            pick = rr_pick(valid_prev, m_ptr);
            check("grant_onehot", 32'($countones(req_ready)), 32'd1);
            check("grant_rr", 32'(gi), 32'(pick));
            check("grant_end_high", 32'(end_prev), 32'd1);
            check("grant_idle", 32'(busy_m), 32'd0);
            check("grant_cmd", 32'({i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2}),
                  32'({c_read[gi], c_addr[gi], c_wlen[gi], c_wdata[gi]}));
            check("rdata_hold", 32'(rsp_rdata), 32'(last_rdata));
            m_ptr   = gi;
            busy_m  = 1'b1;
            owner   = gi;
            t_grant = cyc;
            grants++;
            gseq.push_back(gi);
            req_valid[gi] = 1'b0;
        end
    endtask

    task automatic core_model();
        if (core_ph == 0) begin
            if (i2c_start && core_mode != 1) begin
                core_ph  = 1;
                core_cnt = $urandom_range(0, 2);
            end
        end else if (core_ph == 1) begin
            if (core_cnt == 0) begin
                i2c_end  = 1'b0;
                core_ph  = 2;
                core_cnt = $urandom_range(1, 6);
            end else begin
                core_cnt--;
            end
        end else if (core_mode != 2) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_rdata  = (force_rd >= 0) ? 8'(force_rd) : 8'($urandom);
                core_ack    = (ack_mode == 2) ? 1'b1 :
                              (ack_mode == 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
                i2c_rdata   = core_rdata;
                i2c_ack_err = core_ack;
                i2c_end     = 1'b1;
                core_ph     = 0;
            end
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
                if (req_mode == 1 || (req_mode == 2 && $urandom_range(0, 2) == 0)) begin
                    set_cmd(i, 1'($urandom), 7'($urandom), 1'($urandom), 16'($urandom));
                end
            end else if (req_mode == 2 && $urandom_range(0, 15) == 0) begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        core_model();
        drive_reqs();
        valid_prev = req_valid;
        end_prev   = i2c_end;
    endtask

    task automatic wait_rsps(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (resps < target && n < budget) begin
            step();
            n++;
        end
        if (resps < target) check(tag, 32'(resps), 32'(target));
    endtask

    task automatic wait_grants(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (gseq.size() < target && n < budget) begin
            step();
            n++;
        end
        if (gseq.size() < target) check(tag, 32'(gseq.size()), 32'(target));
    endtask

    task automatic stop_reqs();
        req_mode   = 0;
        req_valid  = '0;
        valid_prev = '0;
    endtask

    task automatic check_rr_start(input string tag);
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < gseq.size()) check(tag, 32'(gseq[i]), 32'(exp_seq[i]));
        end
    endtask

    initial begin
        int g0;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_start", 32'(i2c_start), 32'd0);
        check("reset_cmd", 32'({i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2}), 32'd0);
        check("reset_rsp", 32'({rsp_rdata, rsp_error, rsp_timeout}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // All requesters always pending: grants 0,1,2,3,0 from the reset pointer
        req_mode = 1;
        wait_grants(8, 300, "wait_rr");
        check_rr_start("rr_order");
        stop_reqs();
        wait_rsps(grants, 100, "drain_rr");

        // Single write from requester 0
        ack_mode  = 1;
        saw_start = 1'b0;
        set_cmd(0, 1'b0, 7'h20, 1'b1, 16'h0900);
        wait_rsps(resps + 1, 100, "wait_single");
        check("single_owner", 32'(r_owner), 32'd0);
        check("single_err", 32'(r_err), 32'd0);
        check("single_start_seen", 32'(saw_start), 32'd1);
        check("single_addr", 32'(i2c_addr), 32'h20);
        check("single_wdata", 32'({i2c_wdata1, i2c_wdata2}), 32'h0900);

        // Read by requester 2 returning 0xA5
        force_rd = 8'hA5;
        set_cmd(2, 1'b1, 7'h51, 1'b0, 16'h1200);
        wait_rsps(resps + 1, 100, "wait_read");
        check("read_owner", 32'(r_owner), 32'd2);
        check("read_rdata", 32'(rsp_rdata), 32'hA5);
        force_rd = -1;

        // NACK from the core, then the next requester is served
        ack_mode = 2;
        set_cmd(3, 1'b0, 7'h33, 1'b0, 16'h5500);
        set_cmd(0, 1'b1, 7'h44, 1'b1, 16'hAA55);
        wait_rsps(resps + 1, 100, "wait_nack");
        check("nack_owner", 32'(r_owner), 32'd3);
        check("nack_flags", 32'({r_err, r_to}), 32'b10);
        wait_rsps(resps + 1, 100, "wait_after_nack");
        check("after_nack_owner", 32'(r_owner), 32'd0);
        ack_mode = 0;

        // Core ignores start: watchdog abort
        core_mode = 1;
        set_cmd(1, 1'b0, 7'h10, 1'b0, 16'h0100);
        wait_rsps(resps + 1, 200, "wait_hang");
        check("hang_flags", 32'({r_err, r_to}), 32'b11);
        core_mode = 0;

        // Core stuck busy: abort, then no grant while i2c_end stays low
        core_mode = 2;
        set_cmd(2, 1'b0, 7'h22, 1'b0, 16'h0200);
        set_cmd(3, 1'b1, 7'h23, 1'b0, 16'h0300);
        wait_rsps(resps + 1, 200, "wait_stuck");
        check("stuck_owner", 32'(r_owner), 32'd2);
        g0 = grants;
        repeat (20) step();
        check("stuck_no_grant", 32'(grants - g0), 32'd0);
        core_mode = 0;
        core_ph   = 0;
        i2c_end   = 1'b1;
        end_prev  = 1'b1;
        wait_rsps(resps + 1, 100, "wait_unstuck");
        check("unstuck_owner", 32'(r_owner), 32'd3);

        // Random traffic
        req_mode = 2;
        wait_rsps(resps + 40, 4000, "wait_random");
        stop_reqs();
        wait_rsps(grants, 100, "drain_random");

        // Reset while the core is busy
        req_mode = 1;
        n = 0;
        while (!(busy_m && core_ph == 2) && n < 100) begin
            step();
            n++;
        end
        check("reach_busy", 32'(core_ph), 32'd2);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_start", 32'(i2c_start), 32'd0);
        check("rst_async_outs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout}),
              32'd0);
        check("rst_async_cmd", 32'({i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2}), 32'd0);
        if (busy_m) dropped++;
        busy_m     = 1'b0;
        m_ptr      = N - 1;
        core_ph    = 0;
        core_mode  = 0;
        i2c_end    = 1'b1;
        req_mode   = 0;
        req_valid  = '0;
        last_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_quiet", 32'({rsp_valid, req_ready, i2c_start}), 32'd0);
        @(negedge clk);
        reset_n    = 1'b1;
        valid_prev = '0;
        end_prev   = 1'b1;
        gseq.delete();
        req_mode = 1;
        wait_grants(6, 300, "wait_restart");
        check_rr_start("restart_order");
        stop_reqs();
        wait_rsps(grants - dropped, 100, "drain_restart");

        check("dropped_count", 32'(dropped), 32'd1);
        check("grant_rsp_balance", 32'(resps + dropped), 32'(grants));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
